edge_detect_multi: RTL and testbench

//  Multi-channel edge detector: parametrised successor to the single-bit edge_mod.
//  Per channel: optional input synchroniser; per-channel mode (rise/fall/both/off);
//  one-cycle pulse; sticky event flag with clear; saturating event counter.

---
 rtl/edge_pkg.sv | 24 ++
 rtl/edge_chan.sv | 105 ++++++++++
 rtl/edge_detect_multi.sv | 64 ++++++
 tb/tb_edge_detect_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   MODE_*  : per-channel 2-bit mode encodings (off / rise / fall / both)
//   qualify : gates raw rise/fall indications with a channel mode
package edge_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic logic qualify(input logic [1:0] mode, input logic rise,
                                   input logic fall);
    logic q;
    q = 1'b0;
    unique case (mode)
      MODE_OFF:  q = 1'b0;
      MODE_RISE: q = rise;
      MODE_FALL: q = fall;
      MODE_BOTH: q = rise | fall;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One edge-detector channel: optional synchroniser, level history, priming,
// registered pulse, sticky flag and saturating event counter.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   cin          raw input (may be asynchronous when SYNC_STAGES > 0)
//   mode         2-bit mode for this channel (see edge_pkg)
//   sticky_clr   level clear of the sticky flag
//   cnt_clr      level clear of the counter
//   pulse_nxt    next-state of pulse (lets the top register any_evt in step)
//   pulse        one-cycle registered pulse per qualified edge
//   level        synchronised input level (history register)
//   sticky       set by pulse, held until cleared
//   cnt          saturating count of pulses
module edge_chan
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [1:0]       mode,
  input  logic             sticky_clr,
  input  logic             cnt_clr,
  output logic             pulse_nxt,
  output logic             pulse,
  output logic             level,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  // Priming spans SYNC_STAGES+1 edges so the zeroed sync chain has filled with
  // real input before the first edge evaluation; otherwise an input held high
  // through reset would show up as a rising edge.
  localparam int unsigned        PrimeW    = $clog2(SYNC_STAGES + 2);
  localparam logic [PrimeW-1:0]  PrimeDone = PrimeW'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CntMax    = {CNT_W{1'b1}};

  logic              sync;
  logic [PrimeW-1:0] prime_q;
  logic              primed;
  logic              level_q;
  logic              pulse_q, pulse_d;
  logic              sticky_q, sticky_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rise, fall;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sync = cin;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= cin;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
    assign sync = sync_q[SYNC_STAGES-1];
  end

  assign primed = (prime_q == PrimeDone);
  assign rise   = sync & ~level_q;
  assign fall   = ~sync & level_q;

  always_comb begin
    pulse_d  = primed & qualify(mode, rise, fall);
    // Sticky and counter follow the registered pulse, so a clear issued during
    // the pulse cycle loses to that pulse.
    sticky_d = pulse_q | (sticky_q & ~sticky_clr);
    cnt_d    = cnt_q;
    if (cnt_clr) begin
      cnt_d = pulse_q ? CNT_W'(1) : '0;
    end else if (pulse_q && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q  <= '0;
      level_q  <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (!primed) prime_q <= prime_q + PrimeW'(1);
      level_q  <= sync;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse_nxt = pulse_d;
  assign pulse     = pulse_q;
  assign level     = level_q;
  assign sticky    = sticky_q;
  assign cnt       = cnt_q;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: CH independent edge_chan instances plus a
// registered OR of all pulses.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   cin[CH]      raw inputs
//   mode[2*CH]   ch i = mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   sticky_clr   per-channel sticky clear (level)
//   cnt_clr      per-channel counter clear (level)
//   pulse        per-channel one-cycle pulse
//   level        per-channel synchronised level
//   sticky       per-channel sticky event flag
//   cnt          ch i = cnt[i*CNT_W +: CNT_W], saturating event count
//   any_evt      OR of all pulse bits, aligned with pulse
module edge_detect_multi
  import edge_pkg::*;
#(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       cin,
  input  logic [2*CH-1:0]     mode,
  input  logic [CH-1:0]       sticky_clr,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       pulse,
  output logic [CH-1:0]       level,
  output logic [CH-1:0]       sticky,
  output logic [CH*CNT_W-1:0] cnt,
  output logic                any_evt
);

  logic [CH-1:0] pulse_nxt;
  logic          any_evt_q;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .cin        (cin[i]),
      .mode       (mode[2*i +: 2]),
      .sticky_clr (sticky_clr[i]),
      .cnt_clr    (cnt_clr[i]),
      .pulse_nxt  (pulse_nxt[i]),
      .pulse      (pulse[i]),
      .level      (level[i]),
      .sticky     (sticky[i]),
      .cnt        (cnt[i*CNT_W +: CNT_W])
    );
  end

  // Registered from the channels' next-state so it lands on the pulse cycle.
  always_ff @(posedge clk) begin
    if (rst) any_evt_q <= 1'b0;
    else     any_evt_q <= |pulse_nxt;
  end

  assign any_evt = any_evt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: a 3-stage-latency build (SYNC_STAGES=2,
// CNT_W=3) driven from a vector table plus hand sequences, and a SYNC_STAGES=0
// build checked for single-cycle latency.
module tb_edge_detect_multi;

  logic        clk;
  // Build A: SYNC_STAGES=2, CNT_W=3
  logic        rst;
  logic [3:0]  cin, sticky_clr, cnt_clr;
  logic [7:0]  mode;
  logic [3:0]  pulse, level, sticky;
  logic [11:0] cnt;
  logic        any_evt;
  // Build B: SYNC_STAGES=0, CNT_W=8
  logic        rst_b;
  logic [3:0]  cin_b, sticky_clr_b, cnt_clr_b;
  logic [7:0]  mode_b;
  logic [3:0]  pulse_b, level_b, sticky_b;
  logic [31:0] cnt_b;
  logic        any_evt_b;

  int n_checks = 0;
  int n_fail   = 0;

  edge_detect_multi #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cin        (cin),
    .mode       (mode),
    .sticky_clr (sticky_clr),
    .cnt_clr    (cnt_clr),
    .pulse      (pulse),
    .level      (level),
    .sticky     (sticky),
    .cnt        (cnt),
    .any_evt    (any_evt)
  );

  edge_detect_multi #(.CH(4), .SYNC_STAGES(0), .CNT_W(8)) u_dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .cin        (cin_b),
    .mode       (mode_b),
    .sticky_clr (sticky_clr_b),
    .cnt_clr    (cnt_clr_b),
    .pulse      (pulse_b),
    .level      (level_b),
    .sticky     (sticky_b),
    .cnt        (cnt_b),
    .any_evt    (any_evt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  cin;
    logic [7:0]  mode;
    logic [3:0]  pulse;
    logic        any;
    logic [3:0]  level;
    logic [3:0]  sticky;
    logic [11:0] cnt;
  } vec_t;

  vec_t tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after an edge, then move to 1 time unit after the next edge.
  task automatic step(input logic r, input logic [3:0] c, input logic [7:0] m,
                      input logic [3:0] sc, input logic [3:0] cc);
    rst = r; cin = c; mode = m; sticky_clr = sc; cnt_clr = cc;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic r, input logic [3:0] c, input logic [7:0] m);
    rst_b = r; cin_b = c; mode_b = m;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] c;
  logic       e;

  initial begin
    rst = 1'b1; cin = 4'hF; mode = 8'hFF; sticky_clr = '0; cnt_clr = '0;
    rst_b = 1'b1; cin_b = 4'hF; mode_b = 8'hFF; sticky_clr_b = '0; cnt_clr_b = '0;

    // Reset with inputs high, priming, then modes 01/10/11/00 on ch0..3
    tbl[0]  = '{1'b1, 4'hF, 8'hFF, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[1]  = '{1'b1, 4'hF, 8'hFF, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[2]  = '{1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[3]  = '{1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[4]  = '{1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 4'hF, 4'h0, 12'h000};
    tbl[5]  = '{1'b0, 4'hF, 8'hFF, 4'h0, 1'b0, 4'hF, 4'h0, 12'h000};
    tbl[6]  = '{1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4'hF, 4'h0, 12'h000};
    tbl[7]  = '{1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4'hF, 4'h0, 12'h000};
    tbl[8]  = '{1'b0, 4'h0, 8'h00, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[9]  = '{1'b0, 4'h0, 8'h39, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[10] = '{1'b0, 4'hF, 8'h39, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[11] = '{1'b0, 4'hF, 8'h39, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000};
    tbl[12] = '{1'b0, 4'hF, 8'h39, 4'h5, 1'b1, 4'hF, 4'h0, 12'h000};
    tbl[13] = '{1'b0, 4'h0, 8'h39, 4'h0, 1'b0, 4'hF, 4'h5, 12'h041};
    tbl[14] = '{1'b0, 4'h0, 8'h39, 4'h0, 1'b0, 4'hF, 4'h5, 12'h041};
    tbl[15] = '{1'b0, 4'h0, 8'h39, 4'h6, 1'b1, 4'h0, 4'h5, 12'h041};
    tbl[16] = '{1'b0, 4'h0, 8'h39, 4'h0, 1'b0, 4'h0, 4'h7, 12'h089};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].rst, tbl[i].cin, tbl[i].mode, 4'h0, 4'h0);
      check($sformatf("row%0d pulse", i),   32'(pulse),   32'(tbl[i].pulse));
      check($sformatf("row%0d any_evt", i), 32'(any_evt), 32'(tbl[i].any));
      check($sformatf("row%0d level", i),   32'(level),   32'(tbl[i].level));
      check($sformatf("row%0d sticky", i),  32'(sticky),  32'(tbl[i].sticky));
      check($sformatf("row%0d cnt", i),     32'(cnt),     32'(tbl[i].cnt));
    end

    // Sticky: clear-vs-set priority on ch0
    step(1'b0, 4'h0, 8'h39, 4'hF, 4'hF);
    check("sticky cleared", 32'(sticky), 32'h0);
    check("cnt cleared", 32'(cnt), 32'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    check("sticky rise1 pulse", 32'(pulse), 32'h1);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    check("sticky set", 32'(sticky), 32'h1);
    check("sticky pulse width", 32'(pulse), 32'h0);
    step(1'b0, 4'h0, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h0, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h0, 8'h39, 4'h0, 4'h0);
    check("fall ignored in rise mode", 32'(pulse), 32'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    step(1'b0, 4'h1, 8'h39, 4'h0, 4'h0);
    check("sticky rise2 pulse", 32'(pulse), 32'h1);
    step(1'b0, 4'h1, 8'h39, 4'h1, 4'h0);
    check("sticky set wins over clr", 32'(sticky), 32'h1);
    step(1'b0, 4'h1, 8'h39, 4'h1, 4'h0);
    check("sticky clr alone", 32'(sticky), 32'h0);
    check("cnt ch0 two rises", 32'(cnt), 32'h002);

    // Counter saturation on ch1 (CNT_W=3)
    step(1'b0, 4'h1, 8'hFF, 4'h0, 4'hF);
    check("cnt clear before sat", 32'(cnt), 32'h0);
    c = 4'h1;
    for (int i = 0; i < 10; i++) begin
      c[1] = ~c[1];
      step(1'b0, c, 8'hFF, 4'h0, 4'h0);
      if (i == 5) check("cnt ch1 mid-run", 32'(cnt), 32'h018);
    end
    for (int i = 0; i < 4; i++) step(1'b0, c, 8'hFF, 4'h0, 4'h0);
    check("cnt ch1 saturated", 32'(cnt), 32'h038);
    check("no pulse after toggles", 32'(pulse), 32'h0);
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'h0);
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'h0);
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'h0);
    check("cnt_clr pulse due", 32'(pulse), 32'h2);
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'h2);
    check("cnt_clr with pulse", 32'(cnt), 32'h008);
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'h2);
    check("cnt_clr alone", 32'(cnt), 32'h000);

    // Back-to-back toggles on ch2 in both-edge mode
    step(1'b0, 4'h3, 8'hFF, 4'h0, 4'hF);
    c = 4'h3;
    for (int j = 1; j <= 10; j++) begin
      if (j <= 6) c[2] = (j % 2 == 1);
      step(1'b0, c, 8'hFF, 4'h0, 4'h0);
      e = (j >= 3) && (j <= 8);
      check($sformatf("b2b pulse j%0d", j), 32'(pulse), 32'({1'b0, e, 2'b00}));
      check($sformatf("b2b any_evt j%0d", j), 32'(any_evt), 32'(e));
    end
    check("b2b cnt ch2", 32'(cnt), 32'h180);
    step(1'b0, 4'h3, 8'hDF, 4'h0, 4'h0);
    check("mode 01 static", 32'(pulse), 32'h0);
    step(1'b0, 4'h3, 8'hEF, 4'h0, 4'h0);
    check("mode 01->10 static", 32'(pulse), 32'h0);
    step(1'b0, 4'h3, 8'hDF, 4'h0, 4'h0);
    check("mode 10->01 static", 32'(pulse), 32'h0);
    check("level static", 32'(level), 32'h3);

    // Reset on the edge where a ch0 pulse is due
    check("sticky before reset", 32'(sticky), 32'h6);
    step(1'b0, 4'h2, 8'hFF, 4'h0, 4'h0);
    step(1'b0, 4'h2, 8'hFF, 4'h0, 4'h0);
    step(1'b1, 4'h2, 8'hFF, 4'h0, 4'h0);
    check("midrst pulse", 32'(pulse), 32'h0);
    check("midrst any_evt", 32'(any_evt), 32'h0);
    check("midrst sticky", 32'(sticky), 32'h0);
    check("midrst cnt", 32'(cnt), 32'h0);
    check("midrst level", 32'(level), 32'h0);
    step(1'b0, 4'h2, 8'hFF, 4'h0, 4'h0);

    // SYNC_STAGES=0 build: priming and one-cycle latency
    step_b(1'b0, 4'hF, 8'hFF);
    check("b prime level", 32'(level_b), 32'hF);
    check("b prime pulse", 32'(pulse_b), 32'h0);
    step_b(1'b0, 4'hF, 8'hFF);
    check("b no spurious", 32'(pulse_b), 32'h0);
    step_b(1'b0, 4'h0, 8'h00);
    check("b off fall", 32'(pulse_b), 32'h0);
    check("b off level", 32'(level_b), 32'h0);
    step_b(1'b0, 4'h0, 8'h39);
    check("b mode change", 32'(pulse_b), 32'h0);
    step_b(1'b0, 4'hF, 8'h39);
    check("b rise pulse", 32'(pulse_b), 32'h5);
    check("b rise any_evt", 32'(any_evt_b), 32'h1);
    check("b rise level", 32'(level_b), 32'hF);
    step_b(1'b0, 4'h0, 8'h39);
    check("b fall pulse", 32'(pulse_b), 32'h6);
    check("b sticky", 32'(sticky_b), 32'h5);
    step_b(1'b0, 4'h0, 8'h39);
    check("b idle pulse", 32'(pulse_b), 32'h0);
    check("b sticky all", 32'(sticky_b), 32'h7);
    check("b cnt", cnt_b, 32'h0002_0101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
